// File: rtl/pezaris_seq_ctrl.sv
// pezaris_seq_ctrl: sequential signed multiplier, one carry-save row per cycle, Pezaris sign handling.
// The +1 that completes the sign-row negation is folded in as an extra carry-save step before the final add.
module pezaris_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*WIDTH-1:0]        product,
    output logic                      busy,
    output logic [$clog2(WIDTH)-1:0]  row_idx
);
    localparam int PW = 2 * WIDTH;
    localparam int RW = $clog2(WIDTH);
    localparam logic [RW-1:0] LAST = RW'(WIDTH - 1);
    localparam logic [PW-1:0] INJ = PW'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q, pp;
    logic [PW-1:0]    sum, carry, ext, row, sum_nx, carry_nx;
    logic             inj_done;

    always_comb begin
        pp       = a_q & {WIDTH{b_q[row_idx]}};
        ext      = {{WIDTH{pp[WIDTH-1]}}, pp};
        row      = state == RESOLVE ? INJ : row_idx == LAST ? (~ext) << (WIDTH - 1) : ext << row_idx;
        sum_nx   = sum ^ carry ^ row;
        carry_nx = ((sum & carry) | (sum & row) | (carry & row)) << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    state_nx = in_valid ? ACCUM : IDLE;
                ACCUM:   state_nx = row_idx == LAST ? RESOLVE : ACCUM;
                RESOLVE: state_nx = inj_done ? DONE : RESOLVE;
                DONE:    state_nx = out_ready ? IDLE : DONE;
            endcase
        end
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
    end

    // Operands are captured only in IDLE so later changes on a/b are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sum      <= '0;
            carry    <= '0;
            row_idx  <= '0;
            inj_done <= 1'b0;
            product  <= '0;
        end else if (abort) begin
            sum      <= '0;
            carry    <= '0;
            row_idx  <= '0;
            inj_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    sum      <= '0;
                    carry    <= '0;
                    row_idx  <= '0;
                    inj_done <= 1'b0;
                end
                ACCUM: begin
                    sum     <= sum_nx;
                    carry   <= carry_nx;
                    row_idx <= row_idx == LAST ? '0 : row_idx + RW'(1);
                end
                RESOLVE: begin
                    if (!inj_done) begin
                        sum      <= sum_nx;
                        carry    <= carry_nx;
                        inj_done <= 1'b1;
                    end else begin
                        product  <= sum + carry;
                        inj_done <= 1'b0;
                    end
                end
                DONE: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pezaris_seq_ctrl.sv
// tb_pezaris_seq_ctrl: directed and randomized checks of the sequential multiplier against plain a*b.
module tb_pezaris_seq_ctrl;
    localparam int W = 8;

    logic clk = 0, rst_n = 0, in_valid = 0, abort = 0, out_ready = 0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, busy;
    logic [2*W-1:0] product;
    logic [$clog2(W)-1:0] row_idx;
    int n_cmp = 0, n_bad = 0;

    pezaris_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy), .row_idx(row_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return 16'(p);
    endfunction

    task automatic start_op(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        in_valid = 1; a = x; b = y;
        chk("in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 0; a = W'($urandom); b = W'($urandom);
        chk("busy_after_accept", 32'(busy), 1);
    endtask

    task automatic finish_op(input logic [15:0] exp, input int stall, input logic ab);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 10);
        chk("product", 32'(product), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("hold_product", 32'(product), 32'(exp));
            chk("hold_valid", 32'(out_valid), 1);
        end
        in_valid = 0; out_ready = 1; abort = ab;
        @(negedge clk);
        out_ready = 0; abort = 0;
        chk("released", 32'(out_valid), 0);
        chk("idle_ready", 32'(in_ready), 1);
        chk("kept_product", 32'(product), 32'(exp));
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                          input int stall, input logic ab);
        start_op(x, y);
        finish_op(exp, stall, ab);
    endtask

    task automatic wait_row(input int r);
        int k = 0;
        while (row_idx != 3'(r) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reach_row", 32'(row_idx), 32'(r));
    endtask

    initial begin
        int seen;
        logic [7:0] x, y;
        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_row_idx", 32'(row_idx), 0);
        chk("rst_product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1;

        run_op(8'd3, 8'd5, 16'h000F, 0, 0);
        run_op(8'h80, 8'h80, 16'h4000, 0, 0);
        run_op(8'h80, 8'h7F, 16'hC080, 1, 0);
        run_op(8'hFF, 8'h7F, 16'hFF81, 2, 0);
        run_op(8'd7, 8'hFE, 16'hFFF2, 5, 0);

        // abort mid-operation: product keeps previous result
        start_op(8'd9, 8'd5);
        wait_row(3);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_row", 32'(row_idx), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_product", 32'(product), 32'h0000FFF2);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("abort_no_valid", 32'(seen), 0);
        run_op(8'd2, 8'd2, 16'h0004, 0, 0);

        // abort beats in_valid in IDLE
        @(negedge clk);
        in_valid = 1; abort = 1; a = 8'd11; b = 8'd11;
        @(negedge clk);
        in_valid = 0; abort = 0;
        chk("abort_wins", 32'(busy), 0);

        // abort together with out_ready in DONE completes the transfer
        run_op(8'd6, 8'd7, 16'h002A, 2, 1);
        run_op(8'hFF, 8'hFF, 16'h0001, 0, 0);

        // asynchronous reset mid-operation
        start_op(8'd100, 8'd3);
        wait_row(5);
        #2 rst_n = 0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_row_idx", 32'(row_idx), 0);
        chk("arst_product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1; in_valid = 1; a = 8'd3; b = 8'd5;
        @(negedge clk);
        in_valid = 0;
        chk("first_accept", 32'(busy), 1);
        finish_op(16'h000F, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            if ($urandom_range(0, 15) == 0) x = 8'h80;
            if ($urandom_range(0, 15) == 0) y = 8'h80;
            run_op(x, y, ref_mul(x, y), $urandom_range(0, 3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
